// File: rtl/car_traffic.sv
// car_traffic: lane car position generator for the crossing game.
// Eight cars advance by a fixed per-lane pixel step on every movement tick.
// Odd lanes move right, even lanes move left, and positions wrap around the
// visible width. The tick period shrinks as speed_car rises, and a drop in
// speed_car restarts the traffic pattern from the initial layout.
//
// Output timing: step_tick is a one-cycle pulse raised in the same cycle
// the new positions first appear. Consumers may sample car_x* at any time;
// the positions are stable between pulses. There is no back-pressure.
module car_traffic #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned BASE_PERIOD = 250000,
  parameter int unsigned PERIOD_STEP = 8000,
  parameter int unsigned MIN_PERIOD  = 20000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] speed_car,
  input  logic       hold,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [9:0] car_x5,
  output logic [9:0] car_x6,
  output logic [9:0] car_x7,
  output logic [9:0] car_x8,
  output logic       step_tick,
  output logic       o_dbg_state
);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [9:0] INIT_X [8] = '{10'd0, 10'd80, 10'd160, 10'd240,
                                        10'd320, 10'd400, 10'd480, 10'd560};
  localparam logic [10:0] STEP_X [8] = '{11'd2, 11'd3, 11'd4, 11'd2,
                                         11'd3, 11'd4, 11'd2, 11'd3};
  localparam logic [10:0] W_H = 11'(H_DISPLAY);

  state_t      w_state;
  state_t      r_state;
  logic [4:0]  r_speed_q;
  logic [31:0] r_cnt;
  logic [9:0]  r_x [8];
  logic        r_step_tick;

  logic [31:0] w_dec;
  logic [31:0] w_diff;
  logic [31:0] w_period;
  logic        w_fire;
  logic        w_restart;
  logic [10:0] w_ext [8];
  logic [9:0]  w_nx [8];

  // Mode is chosen directly by hold: HOLD freezes counter and positions.
  always_comb begin
    w_state = S_RUN;
    if (hold) w_state = S_HOLD;
  end

  // Record the mode seen on each edge so it can be observed externally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_RUN;
    else     r_state <= w_state;
  end

  // Tick period from the registered speed, clamped at MIN_PERIOD (also on underflow).
  always_comb begin
    w_dec    = 32'(r_speed_q) * PERIOD_STEP;
    w_diff   = BASE_PERIOD - w_dec;
    w_period = w_diff;
    if ((w_dec > BASE_PERIOD) || (w_diff < MIN_PERIOD)) w_period = MIN_PERIOD;
    // >= rather than == so a period that shrinks mid-count fires promptly.
    w_fire    = (r_cnt >= (w_period - 32'd1));
    w_restart = (speed_car < r_speed_q);
  end

  // Candidate next positions; 11-bit sums keep the wrap compare overflow-free.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_ext[i] = {1'b0, r_x[i]};
      w_nx[i]  = r_x[i];
      if ((i % 2) == 0) begin
        if ((w_ext[i] + STEP_X[i]) >= W_H) w_nx[i] = 10'(w_ext[i] + STEP_X[i] - W_H);
        else                               w_nx[i] = 10'(w_ext[i] + STEP_X[i]);
      end else begin
        if (w_ext[i] < STEP_X[i]) w_nx[i] = 10'(w_ext[i] + W_H - STEP_X[i]);
        else                      w_nx[i] = 10'(w_ext[i] - STEP_X[i]);
      end
    end
  end

  // Counter, positions and pulse; priority is restart > hold > step/count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_speed_q   <= 5'd0;
      r_cnt       <= 32'd0;
      r_step_tick <= 1'b0;
      for (int i = 0; i < 8; i++) r_x[i] <= INIT_X[i];
    end else begin
      r_speed_q <= speed_car;
      if (w_restart) begin
        r_cnt       <= 32'd0;
        r_step_tick <= 1'b0;
        for (int i = 0; i < 8; i++) r_x[i] <= INIT_X[i];
      end else if (w_state == S_HOLD) begin
        r_step_tick <= 1'b0;
      end else if (w_fire) begin
        r_cnt       <= 32'd0;
        r_step_tick <= 1'b1;
        for (int i = 0; i < 8; i++) r_x[i] <= w_nx[i];
      end else begin
        r_cnt       <= r_cnt + 32'd1;
        r_step_tick <= 1'b0;
      end
    end
  end

  assign car_x1      = r_x[0];
  assign car_x2      = r_x[1];
  assign car_x3      = r_x[2];
  assign car_x4      = r_x[3];
  assign car_x5      = r_x[4];
  assign car_x6      = r_x[5];
  assign car_x7      = r_x[6];
  assign car_x8      = r_x[7];
  assign step_tick   = r_step_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_car_traffic.sv
// Bench for car_traffic with a short period (BASE 10, STEP 2, MIN 3).
// The driver pushes every expected pulse (cycle number plus positions) into
// exp_q as it issues stimulus; the monitor pops and compares on each pulse.
module tb_car_traffic;

  localparam int W = 112;

  logic       CLK;
  logic       RST;
  logic [4:0] speed_car;
  logic       hold;
  logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8;
  logic       step_tick;
  logic       o_dbg_state;

  logic [79:0] dut_pos;
  logic [9:0]  dut_x [8];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int total = 0;
  int bad   = 0;
  int cyc;
  int m_x [8];
  int steps [8] = '{2, 3, 4, 2, 3, 4, 2, 3};
  int wk [8] = '{26, 27, 119, 120, 240, 241, 319, 320};
  int wl [8] = '{1, 1, 2, 2, 1, 1, 0, 0};
  int wv [8] = '{2, 639, 636, 0, 0, 637, 638, 0};
  logic [79:0] init_pos;
  logic [79:0] first_pos;

  car_traffic #(
    .H_DISPLAY(640), .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(3)
  ) dut (
    .CLK(CLK), .RST(RST), .speed_car(speed_car), .hold(hold),
    .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
    .car_x5(car_x5), .car_x6(car_x6), .car_x7(car_x7), .car_x8(car_x8),
    .step_tick(step_tick), .o_dbg_state(o_dbg_state)
  );

  assign dut_pos = {car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8};
  assign dut_x[0] = car_x1;
  assign dut_x[1] = car_x2;
  assign dut_x[2] = car_x3;
  assign dut_x[3] = car_x4;
  assign dut_x[4] = car_x5;
  assign dut_x[5] = car_x6;
  assign dut_x[6] = car_x7;
  assign dut_x[7] = car_x8;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle number: edge n after reset release makes cyc == n.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [79:0] model_pos();
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[69:0], 10'(m_x[i])};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_x[i] = i * 80;
  endtask

  task automatic model_step();
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) m_x[i] = (m_x[i] + steps[i]) % 640;
      else              m_x[i] = (m_x[i] + 640 - steps[i]) % 640;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_ticks(input int first, input int spacing, input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      exp_q.push_back({32'(first + k * spacing), model_pos()});
    end
  endtask

  // Advance to 1 time unit after edge number t.
  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      while (exp_q.size() > 0 && exp_q[0][111:80] < 32'(cyc)) begin
        mon_e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_tick: no pulse at cycle %0d (now %0d)", mon_e[111:80], cyc);
      end
      if (step_tick) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_tick: pulse at cycle %0d, none expected", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tick_cycle", 128'(cyc), 128'(mon_e[111:80]));
          chk("tick_pos", 128'(dut_pos), 128'(mon_e[79:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    speed_car = 5'd0;
    hold = 1'b0;
    init_pos  = {10'd0, 10'd80, 10'd160, 10'd240, 10'd320, 10'd400, 10'd480, 10'd560};
    first_pos = {10'd2, 10'd77, 10'd164, 10'd238, 10'd323, 10'd396, 10'd482, 10'd557};
    model_reset();
    #12;
    chk("reset_pos", 128'(dut_pos), 128'(init_pos));
    chk("reset_tick", 128'(step_tick), 128'(0));
    @(negedge CLK);
    RST = 1'b0;

    // Speed 0: period 10.
    push_ticks(10, 10, 3);
    goto_cyc(10);
    chk("first_tick_pulse", 128'(step_tick), 128'(1));
    chk("first_tick_pos", 128'(dut_pos), 128'(first_pos));
    goto_cyc(30);

    // Speed 2 -> 6, speed 4 -> clamp 3, speed 31 -> clamp 3.
    speed_car = 5'd2;
    push_ticks(36, 6, 3);
    goto_cyc(48);
    speed_car = 5'd4;
    push_ticks(51, 3, 3);
    goto_cyc(57);
    speed_car = 5'd31;
    push_ticks(60, 3, 3);
    goto_cyc(66);

    // Restart 31 -> 0: layout returns on edge 67, next pulse 10 later.
    speed_car = 5'd0;
    goto_cyc(67);
    chk("restart_pos", 128'(dut_pos), 128'(init_pos));
    chk("restart_tick", 128'(step_tick), 128'(0));
    model_reset();
    push_ticks(77, 10, 1);

    // Hold with cnt=4 for 25 edges (82..106): pulse due at 87 slides to 112.
    goto_cyc(81);
    hold = 1'b1;
    goto_cyc(90);
    chk("hold_state", 128'(o_dbg_state), 128'(1));
    goto_cyc(106);
    chk("hold_frozen", 128'(dut_pos), 128'(model_pos()));
    hold = 1'b0;
    push_ticks(112, 10, 2);
    goto_cyc(108);
    chk("run_state", 128'(o_dbg_state), 128'(0));
    goto_cyc(122);

    // Increase 0 -> 1 is not a restart; period becomes 8.
    speed_car = 5'd1;
    goto_cyc(123);
    chk("no_restart_pos", 128'(dut_pos), 128'(model_pos()));
    push_ticks(130, 8, 1);
    goto_cyc(130);

    // Restart on edge 131, then speed 4 (period 3): pulse k at 131+3k.
    speed_car = 5'd0;
    goto_cyc(131);
    chk("restart2_pos", 128'(dut_pos), 128'(init_pos));
    speed_car = 5'd4;
    model_reset();
    push_ticks(134, 3, 330);
    for (int j = 0; j < 8; j++) begin
      goto_cyc(131 + 3 * wk[j]);
      chk($sformatf("wrap_k%0d_lane%0d", wk[j], wl[j] + 1), 128'(dut_x[wl[j]]), 128'(wv[j]));
    end
    goto_cyc(1121);

    // Restart, one pulse at 1132, then async reset while cnt = 7.
    speed_car = 5'd0;
    goto_cyc(1122);
    model_reset();
    push_ticks(1132, 10, 1);
    goto_cyc(1139);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_pos", 128'(dut_pos), 128'(init_pos));
    chk("async_rst_tick", 128'(step_tick), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    push_ticks(10, 10, 1);
    goto_cyc(12);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
